servo_duty_sequencer: RTL
=========================

Name: servo_duty_sequencer

Overview:
Upstream command stage for the 5-channel servo PWM bank. Accepts per-channel target-position commands over a valid/ready interface. Slews each channel's 7-bit duty value toward its target at a bounded rate, so servos never jump. Drives duty_cycle_1..duty_cycle_5 of the servo controller bank directly and reports per-channel busy/done status to the game controller.

Parameters:
STEP_DIV, 1000000, clock cycles per slew tick; legal range 2..2^24
STEP, 1, duty units moved per tick; legal range 1..16
DUTY_MIN, 5, lowest legal duty; targets below it are clamped up
DUTY_MAX, 25, highest legal duty; targets above it are clamped down
DUTY_INIT, 15, duty and target value after reset; must satisfy DUTY_MIN <= DUTY_INIT <= DUTY_MAX

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted
cmd_channel  in  3  target channel, 0..4; values 5..7 are illegal
cmd_target  in  7  requested duty value
cmd_err  out  1  one-cycle pulse: illegal channel was dropped
hold  in  1  freezes all slewing while high
duty_cycle_1 .. duty_cycle_5  out  7 each  current duty per channel (channel 0..4)
busy  out  5  bit i high while channel i duty != target i
move_done  out  5  bit i pulses for one cycle when channel i completes a move

Behaviour:
- Reset (async assert, sync release):
  - all duty and target registers = DUTY_INIT
  - prescaler = 0
  - cmd_ready = 0, cmd_err = 0, busy = 0, move_done = 0
  - cmd_ready rises on the first clk edge after reset deasserts, then stays 1.
- Handshake:
  - Command accepted on a rising edge where cmd_valid && cmd_ready.
  - Legal channel: target[ch] <= clamp(cmd_target, DUTY_MIN, DUTY_MAX). The new target is used from the next cycle on.
  - Illegal channel (5..7): no state change; cmd_err = 1 in the following cycle.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - tick is asserted in the cycle the count equals STEP_DIV-1.
  - While hold = 1, the counter does not advance and tick is suppressed. Counting resumes from the held value.
- Slew, on tick, per channel, using registered duty d and target t:
  - if |t - d| <= STEP then d <= t
  - else d <= d + STEP when t > d, or d <= d - STEP when t < d
  - Compute in 8-bit unsigned; no overflow is possible because clamped values are <= 127.
- Simultaneous command and tick on the same channel: the tick uses the old target; the new target takes effect next cycle.
- Retarget mid-move: slewing continues from the current duty toward the new target. No move_done is issued for the abandoned target.
- busy[i] = registered (duty[i] != target[i]). It updates the cycle after a command or tick changes either value.
- move_done[i]: one-cycle pulse, asserted in the cycle after either:
  - a tick makes duty[i] equal target[i], or
  - a command is accepted whose clamped target equals the current duty[i] (zero-length move).
- Reset mid-move: duty snaps to DUTY_INIT immediately. No done pulse is issued.
- Latency: a command is visible on busy 1 cycle after acceptance. A full move takes ceil(|t-d|/STEP) ticks.

Decomposition:
- Shared package servo_pkg holds:
  - NUM_SERVOS = 5
  - DUTY_W = 7
  - CH_W = 3
  - the clamp function
- One sub-module, servo_slew_channel, instantiated 5 times:
  - inputs: tick, load, load_target
  - outputs: duty, busy, done
- The top level holds the prescaler, the command decode and cmd_err.

Test Plan:
- Reset check (STEP_DIV=4, STEP=1) -> all duty_cycle_N=15, busy=0, cmd_ready=0 during reset and 1 one cycle after release.
- Command ch0 target 20 -> busy[0]=1 next cycle; duty_cycle_1 steps 16,17,18,19,20 on successive ticks (4 clocks apart); move_done[0] pulses once; busy[0] falls.
- Command ch4 target 2 -> clamped to 5; duty_cycle_5 reaches 5 after 10 ticks; no glitch below 5.
- STEP=4, ch1 target 22 from 15 -> duty 19 then 22 (no overshoot); command ch2 target 15 (equal to current) -> move_done[2] next cycle, busy[2] stays 0.
- cmd_channel=6 with target 20 -> cmd_err pulses one cycle; no duty, busy or done changes. Then ch3 retargeted 20 -> 10 mid-move at duty 17 -> duty reverses to 16; only one move_done[3] pulse, at 10.
- hold=1 for 20 cycles mid-move -> duties frozen and prescaler held; after release the next tick arrives at the remaining count. Separately, assert reset mid-move -> duty returns to 15 immediately with no done pulse.

Source files
------------

// File: rtl/servo_duty_sequencer_pkg.sv
// Shared constants, command struct and target clamp for the servo duty sequencer.
package servo_pkg;
  localparam int NUM_SERVOS = 5;
  localparam int DUTY_W     = 7;
  localparam int CH_W       = 3;

  typedef struct packed {
    logic [CH_W-1:0]   channel;
    logic [DUTY_W-1:0] target;
  } servo_cmd_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v,
                                                   input logic [DUTY_W-1:0] lo,
                                                   input logic [DUTY_W-1:0] hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction
endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: holds duty/target and slews duty toward target by STEP per tick.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_target,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);
  localparam logic [7:0]        STEP8 = 8'(STEP);
  localparam logic [DUTY_W-1:0] INIT  = DUTY_W'(DUTY_INIT);

  logic [DUTY_W-1:0] target, duty_n, target_n;
  logic [7:0]        d8, t8, diff;
  logic              done_n;

  // Tick works on the registered target, so a same-cycle load only affects the next tick.
  always_comb begin
    d8       = {1'b0, duty};
    t8       = {1'b0, target};
    diff     = (t8 > d8) ? (t8 - d8) : (d8 - t8);
    duty_n   = duty;
    target_n = load ? load_target : target;
    if (tick) begin
      if (diff <= STEP8)  duty_n = target;
      else if (t8 > d8)   duty_n = DUTY_W'(d8 + STEP8);
      else                duty_n = DUTY_W'(d8 - STEP8);
    end
    done_n = (duty_n == target_n) &&
             ((tick && (duty != target)) || (load && (load_target == duty)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty   <= INIT;
      target <= INIT;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      duty   <= duty_n;
      target <= target_n;
      busy   <= (duty_n != target_n);
      done   <= done_n;
    end
  end
endmodule

// File: rtl/servo_duty_sequencer.sv
// Command front end for the servo PWM bank: prescaler, command decode and per-channel slew.
module servo_duty_sequencer
  import servo_pkg::*;
#(
  parameter int STEP_DIV  = 1000000,
  parameter int STEP      = 1,
  parameter int DUTY_MIN  = 5,
  parameter int DUTY_MAX  = 25,
  parameter int DUTY_INIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CH_W-1:0]       cmd_channel,
  input  logic [DUTY_W-1:0]     cmd_target,
  output logic                  cmd_err,
  input  logic                  hold,
  output logic [DUTY_W-1:0]     duty_cycle_1,
  output logic [DUTY_W-1:0]     duty_cycle_2,
  output logic [DUTY_W-1:0]     duty_cycle_3,
  output logic [DUTY_W-1:0]     duty_cycle_4,
  output logic [DUTY_W-1:0]     duty_cycle_5,
  output logic [NUM_SERVOS-1:0] busy,
  output logic [NUM_SERVOS-1:0] move_done
);
  localparam int                PS_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(STEP_DIV - 1);
  localparam logic [DUTY_W-1:0] LO      = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] HI      = DUTY_W'(DUTY_MAX);

  logic [PS_W-1:0]                    ps_cnt;
  logic                               tick, accept, legal;
  logic [DUTY_W-1:0]                  tgt_clamped;
  logic [NUM_SERVOS-1:0]              load;
  logic [NUM_SERVOS-1:0][DUTY_W-1:0]  duty;
  servo_cmd_t                         cmd;

  assign cmd.channel = cmd_channel;
  assign cmd.target  = cmd_target;

  // Hold freezes the count in place, so the next tick lands on the remaining count.
  assign tick = !hold && (ps_cnt == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ps_cnt <= '0;
    else if (!hold) ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;
  end

  assign accept      = cmd_valid && cmd_ready;
  assign legal       = cmd.channel < CH_W'(NUM_SERVOS);
  assign tgt_clamped = clamp_duty(cmd.target, LO, HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      cmd_err   <= accept && !legal;
    end
  end

  for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
    assign load[i] = accept && legal && (cmd.channel == CH_W'(i));
    servo_slew_channel #(
      .STEP      (STEP),
      .DUTY_INIT (DUTY_INIT)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .load        (load[i]),
      .load_target (tgt_clamped),
      .duty        (duty[i]),
      .busy        (busy[i]),
      .done        (move_done[i])
    );
  end

  assign duty_cycle_1 = duty[0];
  assign duty_cycle_2 = duty[1];
  assign duty_cycle_3 = duty[2];
  assign duty_cycle_4 = duty[3];
  assign duty_cycle_5 = duty[4];
endmodule
